iter_multdiv_unit: RTL and testbench
====================================

// Module: iter_multdiv_unit
// PURPOSE
// Parametrised iterative signed multiply/divide unit for the execute stage of the pipelined processor.
// Executes one radix-2 step per cycle and gives the pipeline a registered busy/stall indication.
// Carries a destination tag from issue to completion.
// Supports flush, early divide-by-zero completion, and explicit overflow/exception reporting.
// PARAMETERS
// WIDTH     32  operand/result width in bits; two's complement; WIDTH >= 4
// TAG_W     5   width of the destination tag carried with each operation
// EARLY_DZ  1   1: divide-by-zero completes in 1 RUN-free cycle; 0: runs the full WIDTH iterations
// PORTS
// clock       in   1        master clock; all state updates on rising edge
// reset       in   1        synchronous, active-low reset
// start_mult  in   1        request signed multiply of operand_a*operand_b
// start_div   in   1        request signed divide operand_a/operand_b
// operand_a   in   WIDTH    multiplicand / dividend
// operand_b   in   WIDTH    multiplier / divisor
// tag_in      in   TAG_W    destination tag, captured on accept
// flush       in   1        abort in-flight operation; no completion is reported
// busy        out  1        high while an operation is iterating (state RUN); pipeline stalls on it
// result_rdy  out  1        one-cycle pulse: result/exception/tag_out valid
// result      out  WIDTH    low WIDTH bits of product, or quotient truncated toward zero
// exception   out  1        overflow or divide-by-zero for the completing operation
// tag_out     out  TAG_W    tag of the completing operation
// BEHAVIOUR
// - Reset (reset==0 at an edge): state=IDLE, counter=0; busy, result_rdy, exception = 0; result and tag_out = 0.
// - States: IDLE, RUN, DONE. busy = (state==RUN); result_rdy = (state==DONE).
// - Accept condition: state!=RUN, flush==0, and exactly one of start_mult/start_div is high.
// - On accept: operands and tag are captured, counter=0, state goes to RUN at the next edge.
// - Rejected starts: both starts high, or start while in RUN. These are ignored with no state change and no queuing.
// - RUN: one iteration per edge, counter increments. After WIDTH iterations the state goes to DONE.
// - Latency: start sampled at end of cycle 0 -> busy high in cycles 1..WIDTH -> result_rdy high in cycle WIDTH+1.
// - DONE lasts exactly one cycle. The next state is RUN if a new start is accepted in DONE, else IDLE.
// - Back-to-back issue: a start accepted in the DONE cycle gives results every WIDTH+1 cycles.
// - result, exception and tag_out are registered at entry to DONE. They hold until the next DONE.
// - Multiply: operands are sign-magnitude converted, shift-add is unsigned over 2*WIDTH bits, and the sign is restored at the end.
// - Multiply: result = low WIDTH bits of the product. exception=1 iff the full product is not representable in WIDTH signed bits.
// - Divide: restoring, unsigned on magnitudes, then sign fixed. Quotient sign = sign(a) XOR sign(b). Remainder is discarded.
// - Divide by zero: result=0, exception=1.
// - Divide by zero with EARLY_DZ=1: RUN is skipped and DONE is in cycle 1; busy is never high.
// - Divide by zero with EARLY_DZ=0: full latency applies.
// - Divide MIN/-1: result = MIN (1 followed by WIDTH-1 zeros), exception=1.
// - Flush in RUN: state goes to IDLE at the next edge and busy falls. result_rdy is not asserted for that operation.
// - Flush in RUN: result, exception and tag_out keep their old values.
// - Flush in DONE: the completion pulse still occurs (already in flight to writeback). Any same-cycle start is rejected.
// - Flush in IDLE: no effect beyond rejecting a same-cycle start.
// - Reset mid-RUN: immediate return to reset values; no completion pulse.
// - Counter: $clog2(WIDTH+1) bits, never wraps. It is compared against WIDTH-1 for the RUN->DONE transition.
// TESTING (WIDTH=32, TAG_W=5)
// 1 start_mult a=7 b=-3 tag=9 in cyc 0 -> busy cyc 1..32; rdy cyc 33; result=0xFFFFFFEB, exc=0, tag_out=9
// 2 start_mult a=0x40000000 b=4 -> cyc 33: result=0x00000000, exc=1
// 2 (cont.) then start_mult in that DONE cycle with a=-1 b=-1 -> cyc 66: result=1, exc=0
// 3 start_div a=-7 b=2 -> cyc 33: result=0xFFFFFFFD, exc=0
// 3 (cont.) start_div a=0x80000000 b=-1 -> result=0x80000000, exc=1
// 4 start_div b=0, EARLY_DZ=1 -> busy never high; rdy cyc 1, result=0, exc=1
// 4 (cont.) same with EARLY_DZ=0 -> rdy cyc 33
// 5 start_mult cyc 0; flush cyc 10 -> busy low from cyc 11; no rdy through cyc 40; outputs unchanged
// 5 (cont.) start_mult+start_div together -> ignored
// 6 reset=0 in cyc 15 of a divide -> cyc 16: all outputs 0, state IDLE; new start accepted cyc 16

Source files
------------

// File: rtl/iter_multdiv_unit_if.sv
// Issue/completion bundle between the execute stage and the iterative multiply/divide unit.
// The unit side uses the slave modport; the issuing pipeline uses master.
interface iter_multdiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             busy;
  logic             result_rdy;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output start_mult, start_div, operand_a, operand_b, tag_in, flush,
    input  busy, result_rdy, result, exception, tag_out
  );

  modport slave (
    input  start_mult, start_div, operand_a, operand_b, tag_in, flush,
    output busy, result_rdy, result, exception, tag_out
  );
endinterface

// File: rtl/iter_multdiv_unit.sv
// Iterative signed multiply/divide unit: one radix-2 step per cycle on operand magnitudes,
// sign restored at completion, with tag carry-through, flush and overflow/div-by-zero reporting.
module iter_multdiv_unit #(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 5,
  parameter bit EARLY_DZ = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  iter_multdiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // MIN maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] absW(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negW(v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t             state_r;
  state_t             stateNext_s;
  logic [CNT_W-1:0]   count_r;
  logic [WIDTH-1:0]   magA_r;
  logic [WIDTH-1:0]   magB_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic               isDiv_r;
  logic               negRes_r;
  logic               divZero_r;
  logic               divOvf_r;
  logic [TAG_W-1:0]   tag_r;

  logic               busy_r;
  logic               rdy_r;
  logic [WIDTH-1:0]   result_r;
  logic               exc_r;
  logic [TAG_W-1:0]   tagOut_r;

  logic               accept_s;
  logic               earlyDz_s;
  logic               lastStep_s;
  logic [WIDTH:0]     mulSum_s;
  logic [2*WIDTH-1:0] prodStep_s;
  logic [WIDTH:0]     divShift_s;
  logic [WIDTH:0]     divDiff_s;
  logic [WIDTH-1:0]   remStep_s;
  logic [WIDTH-1:0]   quoStep_s;
  logic [2*WIDTH-1:0] prodSigned_s;
  logic [WIDTH-1:0]   quoSigned_s;
  logic               mulOvf_s;
  logic [WIDTH-1:0]   finalResult_s;
  logic               finalExc_s;

  // Issue qualification and end-of-iteration detection.
  always_comb begin
    accept_s   = (state_r != RUN) && !bus.flush && (bus.start_mult ^ bus.start_div);
    earlyDz_s  = accept_s && bus.start_div && (bus.operand_b == ZERO_W) && (EARLY_DZ == 1'b1);
    lastStep_s = (state_r == RUN) && !bus.flush && (count_r == LAST_CNT);
  end

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (earlyDz_s) begin
          stateNext_s = DONE;
        end else if (accept_s) begin
          stateNext_s = RUN;
        end else begin
          stateNext_s = IDLE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          stateNext_s = IDLE;
        end else if (count_r == LAST_CNT) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = RUN;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // One radix-2 step: shift-add multiply and restoring divide, both on magnitudes.
  always_comb begin
    mulSum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, magA_r} : {1'b0, ZERO_W});
    prodStep_s = {mulSum_s, prod_r[WIDTH-1:1]};
    divShift_s = {rem_r, quo_r[WIDTH-1]};
    divDiff_s  = divShift_s - {1'b0, magB_r};
    if (!divDiff_s[WIDTH]) begin
      remStep_s = divDiff_s[WIDTH-1:0];
      quoStep_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      remStep_s = divShift_s[WIDTH-1:0];
      quoStep_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign restoration and exception derivation from the final step's values.
  always_comb begin
    prodSigned_s = negRes_r ? neg2W(prodStep_s) : prodStep_s;
    quoSigned_s  = negRes_r ? negW(quoStep_s) : quoStep_s;
    // Representable iff the top WIDTH+1 bits of the signed product are a pure sign extension.
    mulOvf_s     = ~((&prodSigned_s[2*WIDTH-1:WIDTH-1]) | ~(|prodSigned_s[2*WIDTH-1:WIDTH-1]));
    if (isDiv_r) begin
      if (divZero_r) begin
        finalResult_s = ZERO_W;
        finalExc_s    = 1'b1;
      end else if (divOvf_r) begin
        finalResult_s = MIN_W;
        finalExc_s    = 1'b1;
      end else begin
        finalResult_s = quoSigned_s;
        finalExc_s    = 1'b0;
      end
    end else begin
      finalResult_s = prodSigned_s[WIDTH-1:0];
      finalExc_s    = mulOvf_s;
    end
  end

  // Controller state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Operand capture on accept and per-cycle iteration of the datapath.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r   <= ZERO_CNT;
      magA_r    <= ZERO_W;
      magB_r    <= ZERO_W;
      prod_r    <= {ZERO_W, ZERO_W};
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      isDiv_r   <= 1'b0;
      negRes_r  <= 1'b0;
      divZero_r <= 1'b0;
      divOvf_r  <= 1'b0;
      tag_r     <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      count_r   <= ZERO_CNT;
      magA_r    <= absW(bus.operand_a);
      magB_r    <= absW(bus.operand_b);
      prod_r    <= {ZERO_W, absW(bus.operand_b)};
      rem_r     <= ZERO_W;
      quo_r     <= absW(bus.operand_a);
      isDiv_r   <= bus.start_div;
      negRes_r  <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
      divZero_r <= (bus.operand_b == ZERO_W);
      divOvf_r  <= (bus.operand_a == MIN_W) && (bus.operand_b == ONES_W);
      tag_r     <= bus.tag_in;
    end else if ((state_r == RUN) && !bus.flush) begin
      count_r   <= count_r + ONE_CNT;
      prod_r    <= prodStep_s;
      rem_r     <= remStep_s;
      quo_r     <= quoStep_s;
    end else if (state_r == RUN) begin
      count_r   <= ZERO_CNT;
    end
  end

  // Registered status and completion outputs; results load only on entry to DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_r   <= 1'b0;
      rdy_r    <= 1'b0;
      result_r <= ZERO_W;
      exc_r    <= 1'b0;
      tagOut_r <= {TAG_W{1'b0}};
    end else begin
      busy_r <= (stateNext_s == RUN);
      rdy_r  <= (stateNext_s == DONE);
      if (earlyDz_s) begin
        result_r <= ZERO_W;
        exc_r    <= 1'b1;
        tagOut_r <= bus.tag_in;
      end else if (lastStep_s) begin
        result_r <= finalResult_s;
        exc_r    <= finalExc_s;
        tagOut_r <= tag_r;
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.result_rdy = rdy_r;
  assign bus.result     = result_r;
  assign bus.exception  = exc_r;
  assign bus.tag_out    = tagOut_r;

endmodule

// File: tb/tb_iter_multdiv_unit.sv
// Directed bench for iter_multdiv_unit (WIDTH=32, TAG_W=5); a second instance covers EARLY_DZ=0.
module tb_iter_multdiv_unit;

  logic clock = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  always #5 clock = ~clock;

  iter_multdiv_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();
  iter_multdiv_unit_if #(.WIDTH(32), .TAG_W(5)) busZ ();

  iter_multdiv_unit #(.WIDTH(32), .TAG_W(5), .EARLY_DZ(1'b1)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  iter_multdiv_unit #(.WIDTH(32), .TAG_W(5), .EARLY_DZ(1'b0)) dutZ (
    .clock(clock), .reset(reset), .bus(busZ.slave)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIn(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    bus.start_mult = m;
    bus.start_div  = d;
    bus.operand_a  = a;
    bus.operand_b  = b;
    bus.tag_in     = t;
  endtask

  task automatic clrIn();
    bus.start_mult  = 1'b0;
    bus.start_div   = 1'b0;
    bus.flush       = 1'b0;
    busZ.start_mult = 1'b0;
    busZ.start_div  = 1'b0;
    busZ.flush      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clrIn();
    busZ.operand_a = 32'd0; busZ.operand_b = 32'd0; busZ.tag_in = 5'd0;
    setIn(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    tick(); tick();
    vecs++;
    if ({bus.busy, bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== 40'd0) begin
      errs++; $display("FAIL reset_state: got busy=%b rdy=%b res=%h exc=%b tag=%0d want all 0",
                       bus.busy, bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    vecs++;
    if ({busZ.busy, busZ.result_rdy, busZ.result, busZ.exception, busZ.tag_out} !== 40'd0) begin
      errs++; $display("FAIL reset_state_dz0: got busy=%b rdy=%b want 0 0", busZ.busy, busZ.result_rdy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult_basic();
    setIn(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    tick(); clrIn();
    for (int c = 1; c <= 33; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy} !== {c <= 32, c == 33}) begin
        errs++; $display("FAIL mult_basic_timing cyc %0d: got busy/rdy %b want %b",
                         c, {bus.busy, bus.result_rdy}, {c <= 32, c == 33});
      end
      if (c < 33) tick();
    end
    vecs++;
    if ({bus.result, bus.exception, bus.tag_out} !== {32'hFFFF_FFEB, 1'b0, 5'd9}) begin
      errs++; $display("FAIL mult_basic_result: got %h/%b/%0d want ffffffeb/0/9",
                       bus.result, bus.exception, bus.tag_out);
    end
    tick();
  endtask

  task automatic test_mult_overflow_back_to_back();
    setIn(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd3);
    tick(); clrIn();
    for (int c = 1; c <= 33; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy} !== {c <= 32, c == 33}) begin
        errs++; $display("FAIL mult_ovf_timing cyc %0d: got %b want %b",
                         c, {bus.busy, bus.result_rdy}, {c <= 32, c == 33});
      end
      if (c < 33) tick();
    end
    vecs++;
    if ({bus.result, bus.exception, bus.tag_out} !== {32'h0000_0000, 1'b1, 5'd3}) begin
      errs++; $display("FAIL mult_ovf_result: got %h/%b/%0d want 00000000/1/3",
                       bus.result, bus.exception, bus.tag_out);
    end
    setIn(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    tick(); clrIn();
    for (int c = 34; c <= 66; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy} !== {c <= 65, c == 66}) begin
        errs++; $display("FAIL b2b_timing cyc %0d: got %b want %b",
                         c, {bus.busy, bus.result_rdy}, {c <= 65, c == 66});
      end
      if (c < 66) tick();
    end
    vecs++;
    if ({bus.result, bus.exception, bus.tag_out} !== {32'h0000_0001, 1'b0, 5'd4}) begin
      errs++; $display("FAIL b2b_result: got %h/%b/%0d want 00000001/0/4",
                       bus.result, bus.exception, bus.tag_out);
    end
    tick();
    vecs++;
    if ({bus.busy, bus.result_rdy} !== 2'b00) begin
      errs++; $display("FAIL b2b_idle: got %b want 00", {bus.busy, bus.result_rdy});
    end
  endtask

  task automatic test_div();
    setIn(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5);
    tick(); clrIn();
    for (int c = 1; c < 33; c++) tick();
    vecs++;
    if ({bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== {1'b1, 32'hFFFF_FFFD, 1'b0, 5'd5}) begin
      errs++; $display("FAIL div_neg7_by_2: got rdy=%b %h/%b/%0d want 1 fffffffd/0/5",
                       bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    tick();
    setIn(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    tick(); clrIn();
    for (int c = 1; c < 33; c++) tick();
    vecs++;
    if ({bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== {1'b1, 32'h8000_0000, 1'b1, 5'd6}) begin
      errs++; $display("FAIL div_min_by_m1: got rdy=%b %h/%b/%0d want 1 80000000/1/6",
                       bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    setIn(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd2);
    tick(); clrIn();
    for (int c = 1; c < 33; c++) tick();
    vecs++;
    if ({bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== {1'b1, 32'hFFFF_FFF2, 1'b0, 5'd2}) begin
      errs++; $display("FAIL div_100_by_m7: got rdy=%b %h/%b/%0d want 1 fffffff2/0/2",
                       bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    tick();
  endtask

  task automatic test_div_by_zero();
    setIn(1'b0, 1'b1, 32'd123, 32'd0, 5'd7);
    busZ.start_div = 1'b1; busZ.operand_a = 32'd123; busZ.operand_b = 32'd0; busZ.tag_in = 5'd7;
    tick(); clrIn();
    vecs++;
    if ({bus.result, bus.exception, bus.tag_out} !== {32'd0, 1'b1, 5'd7}) begin
      errs++; $display("FAIL dz_early_result: got %h/%b/%0d want 00000000/1/7",
                       bus.result, bus.exception, bus.tag_out);
    end
    for (int c = 1; c <= 33; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy} !== {1'b0, c == 1}) begin
        errs++; $display("FAIL dz_early_timing cyc %0d: got %b want %b",
                         c, {bus.busy, bus.result_rdy}, {1'b0, c == 1});
      end
      vecs++;
      if ({busZ.busy, busZ.result_rdy} !== {c <= 32, c == 33}) begin
        errs++; $display("FAIL dz_full_timing cyc %0d: got %b want %b",
                         c, {busZ.busy, busZ.result_rdy}, {c <= 32, c == 33});
      end
      if (c < 33) tick();
    end
    vecs++;
    if ({busZ.result, busZ.exception, busZ.tag_out} !== {32'd0, 1'b1, 5'd7}) begin
      errs++; $display("FAIL dz_full_result: got %h/%b/%0d want 00000000/1/7",
                       busZ.result, busZ.exception, busZ.tag_out);
    end
    tick();
  endtask

  task automatic test_flush_run();
    setIn(1'b1, 1'b0, 32'd5, 32'd6, 5'd2);
    tick(); clrIn();
    for (int c = 1; c <= 40; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy, bus.result, bus.exception, bus.tag_out}
          !== {c <= 10, 1'b0, 32'd0, 1'b1, 5'd7}) begin
        errs++; $display("FAIL flush_run cyc %0d: got busy=%b rdy=%b %h/%b/%0d want %b 0 00000000/1/7",
                         c, bus.busy, bus.result_rdy, bus.result, bus.exception, bus.tag_out, c <= 10);
      end
      if (c == 10) bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
    end
  endtask

  task automatic test_reject();
    setIn(1'b1, 1'b1, 32'd5, 32'd6, 5'd2);
    for (int c = 1; c <= 3; c++) begin
      tick();
      vecs++;
      if ({bus.busy, bus.result_rdy} !== 2'b00) begin
        errs++; $display("FAIL reject_both cyc %0d: got %b want 00", c, {bus.busy, bus.result_rdy});
      end
    end
    clrIn();
    setIn(1'b1, 1'b0, 32'd5, 32'd6, 5'd2);
    tick(); clrIn();
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) begin
        setIn(1'b0, 1'b1, 32'd100, 32'd3, 5'd11);
        tick(); clrIn();
      end else if (c < 33) begin
        tick();
      end
    end
    vecs++;
    if ({bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== {1'b1, 32'd30, 1'b0, 5'd2}) begin
      errs++; $display("FAIL reject_in_run: got rdy=%b %h/%b/%0d want 1 0000001e/0/2",
                       bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    tick();
    vecs++;
    if ({bus.busy, bus.result_rdy} !== 2'b00) begin
      errs++; $display("FAIL reject_no_queue: got %b want 00", {bus.busy, bus.result_rdy});
    end
  endtask

  task automatic test_flush_done();
    setIn(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd4, 5'd1);
    tick(); clrIn();
    for (int c = 1; c < 33; c++) tick();
    vecs++;
    if ({bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== {1'b1, 32'hFFFF_FFF4, 1'b0, 5'd1}) begin
      errs++; $display("FAIL flush_done_pulse: got rdy=%b %h/%b/%0d want 1 fffffff4/0/1",
                       bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    setIn(1'b1, 1'b0, 32'd9, 32'd9, 5'd8);
    bus.flush = 1'b1;
    tick(); clrIn();
    for (int c = 34; c <= 35; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy, bus.tag_out} !== {2'b00, 5'd1}) begin
        errs++; $display("FAIL flush_done_reject cyc %0d: got busy=%b rdy=%b tag=%0d want 0 0 1",
                         c, bus.busy, bus.result_rdy, bus.tag_out);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    setIn(1'b0, 1'b1, 32'd100, 32'd7, 5'd6);
    tick(); clrIn();
    for (int c = 1; c <= 15; c++) begin
      vecs++;
      if (bus.busy !== 1'b1) begin
        errs++; $display("FAIL reset_mid_busy cyc %0d: got %b want 1", c, bus.busy);
      end
      if (c == 15) reset = 1'b0;
      tick();
    end
    vecs++;
    if ({bus.busy, bus.result_rdy, bus.result, bus.exception, bus.tag_out} !== 40'd0) begin
      errs++; $display("FAIL reset_mid_clear: got busy=%b rdy=%b %h/%b/%0d want all 0",
                       bus.busy, bus.result_rdy, bus.result, bus.exception, bus.tag_out);
    end
    reset = 1'b1;
    setIn(1'b1, 1'b0, 32'd2, 32'd3, 5'd1);
    tick(); clrIn();
    for (int c = 17; c <= 49; c++) begin
      vecs++;
      if ({bus.busy, bus.result_rdy} !== {c <= 48, c == 49}) begin
        errs++; $display("FAIL reset_restart_timing cyc %0d: got %b want %b",
                         c, {bus.busy, bus.result_rdy}, {c <= 48, c == 49});
      end
      if (c < 49) tick();
    end
    vecs++;
    if ({bus.result, bus.exception, bus.tag_out} !== {32'd6, 1'b0, 5'd1}) begin
      errs++; $display("FAIL reset_restart_result: got %h/%b/%0d want 00000006/0/1",
                       bus.result, bus.exception, bus.tag_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_overflow_back_to_back();
    test_div();
    test_div_by_zero();
    test_flush_run();
    test_reject();
    test_flush_done();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
